// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 8N1 UART receiver driven by a 16x oversample tick.
// The line is synchronised, the start bit is confirmed at its midpoint, and
// each data/stop bit is then sampled one full bit period later (its middle).
// A good frame gives a one-cycle oRx_Done with the byte on oRx_Data; a low
// stop bit gives a one-cycle oFrame_Err instead.
module uart_rx_os16 #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int MID        = OVERSAMPLE / 2
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iB_Tick,
    input  logic                 iRx,
    output logic [DATA_BITS-1:0] oRx_Data,
    output logic                 oRx_Done,
    output logic                 oFrame_Err,
    output logic                 oRx_Busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;

    localparam logic [TW-1:0] TICK_MID = TW'(MID - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_meta;
    logic                 rx_s;

    // Two-flop synchroniser; resets to the idle (high) line level so reset
    // release never looks like a start edge.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= iRx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM with registered data, strobes and busy (busy tracks the
    // state being entered, so it is set/cleared on each IDLE transition).
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            oRx_Data   <= '0;
            oRx_Done   <= 1'b0;
            oFrame_Err <= 1'b0;
            oRx_Busy   <= 1'b0;
        end else begin
            oRx_Done   <= 1'b0;
            oFrame_Err <= 1'b0;
            case (state)
                IDLE: begin
                    // Edge detect is ungated by the tick for best alignment.
                    if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        oRx_Busy <= 1'b1;
                    end
                end
                START: begin
                    if (iB_Tick) begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                            end else begin
                                // Line came back high: glitch, not a start bit.
                                state    <= IDLE;
                                oRx_Busy <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (iB_Tick) begin
                        if (tick_cnt == TICK_END) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                state   <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (iB_Tick) begin
                        if (tick_cnt == TICK_END) begin
                            // Leave at mid stop bit so a following start edge
                            // is caught with no idle gap.
                            tick_cnt <= '0;
                            state    <= IDLE;
                            oRx_Busy <= 1'b0;
                            if (rx_s) begin
                                oRx_Data <= shreg;
                                oRx_Done <= 1'b1;
                            end else begin
                                oFrame_Err <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    oRx_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- UART receiver stage. Consumes the 16x-oversampled baud tick from the tick generator, 9600 bps × 16 at 100 MHz.
- Deserialises 8N1 frames from the board RX pin.
- Delivers each byte with a one-cycle done strobe to the downstream RX FIFO write port.
- Sits between the pin/tick generator and the RX FIFO in the UART_FIFO subsystem.

Parameters:
- DATA_BITS, 8: payload bits per frame, sent LSB first.
- OVERSAMPLE, 16: ticks per bit period. Must match the tick generator divider.
- MID, OVERSAMPLE/2: tick count used to sample the middle of the start bit.

Ports:
- iClk  input  1  system clock, 100 MHz.
- iRst  input  1  asynchronous reset, active-high.
- iB_Tick  input  1  oversample tick, one iClk wide, nominally every 651 clocks.
- iRx  input  1  raw serial line, idle high, asynchronous to iClk.
- oRx_Data  output  DATA_BITS  last received byte.
- oRx_Done  output  1  one-cycle strobe when a valid byte is on oRx_Data.
- oFrame_Err  output  1  one-cycle strobe when the stop bit is sampled low.
- oRx_Busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Clocking: single clock iClk. Reset is asynchronous, active-high, on iRst. All flops use posedge iClk, posedge iRst.
- Reset values:
  - oRx_Data = 0, oRx_Done = 0, oFrame_Err = 0, oRx_Busy = 0.
  - State = IDLE. Tick counter and bit counter = 0. Shift register = 0.
  - Both synchroniser flops = 1 (idle line level).
- Input synchroniser: iRx passes through a 2-flop synchroniser. All decisions use the synchronised value rx_s. This adds 2 iClk of latency.
- Tick counter: width $clog2(OVERSAMPLE). Increments only on iB_Tick. Cleared on every state transition.
- Bit counter: width $clog2(DATA_BITS)+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rx_s == 0 (checked on any clock, not gated by tick), clear counters and go to START.
  - START: on each tick, increment. On the tick where the counter == MID-1 (the 8th tick):
    - rx_s == 0: clear counter, go to DATA.
    - rx_s == 1: false start. Go to IDLE with no strobe.
  - DATA: on the tick where the counter == OVERSAMPLE-1, shift right as shreg <= {rx_s, shreg[DATA_BITS-1:1]}, increment the bit counter, clear the tick counter. After the DATA_BITS-th sample, go to STOP.
  - STOP: on the tick where the counter == OVERSAMPLE-1, at mid stop bit:
    - rx_s == 1: oRx_Data <= shreg and oRx_Done <= 1 on the same edge.
    - rx_s == 0: oFrame_Err <= 1. oRx_Data is unchanged.
    - Either way, go to IDLE.
- Back-to-back frames: returning to IDLE at mid stop bit lets the next start edge be detected with no gap.
- Strobes: oRx_Done and oFrame_Err are high for exactly one iClk and are never high together. Default is 0 every cycle.
- Data hold: oRx_Data holds its value until the next good frame. It is valid whenever oRx_Done pulses.
- oRx_Busy: registered, equal to (next state != IDLE).
- Line held low in IDLE: a constant-low line after a framing error restarts START immediately. This is intended; break detection is out of scope.
- Reset mid-frame: iRst at any point returns all state to reset values immediately. No strobe is produced. The receiver then waits for a fresh falling edge.
- Ticks with an idle line: no effect in IDLE.

Test Plan:
- Receive 0x55 with the real tick rate (tick every 651 clks), 8N1 idle high → exactly one oRx_Done. oRx_Data = 0x55 in the same cycle. oFrame_Err stays 0. Done occurs about 9.5 bit periods after the start edge, ±1 tick + 2 clks.
- Back-to-back 0xA3 then 0x00, no idle between frames (tick every 4 clks for speed) → two oRx_Done pulses. Data 0xA3, then 0x00. oRx_Busy drops for at most half a bit between the frames.
- Glitch: line low for 4 ticks, then high → no strobe. State returns to IDLE after the 8th tick. oRx_Data keeps its prior value.
- Framing error: send 0xFF with the stop bit driven low → one oFrame_Err pulse, no oRx_Done. oRx_Data unchanged from the previous 0x55.
- Reset mid-frame: assert iRst during data bit 3 of 0x3C, release, then send 0xC6 → no strobe for the aborted frame. One oRx_Done with 0xC6. All outputs are at reset values while iRst is high.
- Idle with ticks running for 1000 ticks, line high → no strobes, oRx_Busy = 0 throughout.
